// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor: 2-bit counter encoding,
// reset counter value, the branch opcode and the saturating-counter training rule.
package branch_predictor_pkg;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

  localparam ctr_e CTR_RESET = CTR_WNT;

  // RV32 conditional-branch major opcode, also used by the control logic
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // Next counter value: saturating step on a hit, weak allocation on a miss
  function automatic ctr_e ctr_train(input logic hit, input ctr_e ctr, input logic taken);
    ctr_e res;
    if (!hit) begin
      res = taken ? CTR_WT : CTR_WNT;
    end else if (taken) begin
      res = (ctr == CTR_ST) ? CTR_ST : ctr_e'(ctr + 2'd1);
    end else begin
      res = (ctr == CTR_SNT) ? CTR_SNT : ctr_e'(ctr - 2'd1);
    end
    return res;
  endfunction

endpackage

// File: rtl/branch_predictor_table.sv
// Tagged direct-mapped table of 2-bit counters: one combinational read port,
// one synchronous training write port. Optional BRANCH_PREDICTOR_BYPASS_EN forwards same-cycle writes.
module bp_table
  import branch_predictor_pkg::*;
#(
  parameter int unsigned PC_WIDTH = 32,
  parameter int unsigned LINES    = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [PC_WIDTH-1:0] rd_pc_i,
  output logic                rd_hit_o,
  output ctr_e                rd_ctr_o,
  input  logic                wr_en_i,
  input  logic [PC_WIDTH-1:0] wr_pc_i,
  input  logic                wr_taken_i
);

  localparam int unsigned INDEX_BITS = $clog2(LINES);
  localparam int unsigned TAG_W      = PC_WIDTH - INDEX_BITS - 2;

  logic             valid_q [LINES];
  logic [TAG_W-1:0] tag_q   [LINES];
  ctr_e             ctr_q   [LINES];

  logic [INDEX_BITS-1:0] rd_idx;
  logic [TAG_W-1:0]      rd_tag;
  logic [INDEX_BITS-1:0] wr_idx;
  logic [TAG_W-1:0]      wr_tag;
  logic                  wr_hit;
  ctr_e                  wr_ctr;

  logic                  rd_valid;
  logic [TAG_W-1:0]      rd_tag_stored;

  logic unused_pc_bits;

  assign rd_idx = rd_pc_i[INDEX_BITS+1:2];
  assign rd_tag = rd_pc_i[PC_WIDTH-1:INDEX_BITS+2];
  assign wr_idx = wr_pc_i[INDEX_BITS+1:2];
  assign wr_tag = wr_pc_i[PC_WIDTH-1:INDEX_BITS+2];

  assign unused_pc_bits = ^{rd_pc_i[1:0], wr_pc_i[1:0]};

  assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
  assign wr_ctr = ctr_train(wr_hit, ctr_q[wr_idx], wr_taken_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < LINES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        ctr_q[i]   <= CTR_RESET;
      end
    end else if (wr_en_i) begin
      valid_q[wr_idx] <= 1'b1;
      tag_q[wr_idx]   <= wr_tag;
      ctr_q[wr_idx]   <= wr_ctr;
    end
  end

  always_comb begin
    rd_valid      = valid_q[rd_idx];
    rd_tag_stored = tag_q[rd_idx];
    rd_ctr_o      = ctr_q[rd_idx];
`ifdef BRANCH_PREDICTOR_BYPASS_EN
    // Same-index training this cycle: present the entry as it will be after the edge
    if (wr_en_i && (wr_idx == rd_idx)) begin
      rd_valid      = 1'b1;
      rd_tag_stored = wr_tag;
      rd_ctr_o      = wr_ctr;
    end
`endif
  end

  assign rd_hit_o = rd_valid && (rd_tag_stored == rd_tag);

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: predicts in IF, carries the guess to X, flags mispredicts
// and trains the table. Optional macro: BRANCH_PREDICTOR_BYPASS_EN (same-cycle write forwarding).
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int unsigned PC_WIDTH = 32,
  parameter int unsigned LINES    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic [PC_WIDTH-1:0] guess_pc,
  input  logic                guess_is_br,
  output logic                br_pred_taken,
  input  logic [PC_WIDTH-1:0] check_pc,
  input  logic                check_is_br,
  input  logic                check_taken,
  output logic                br_pred_correct
);

  logic rd_hit;
  ctr_e rd_ctr;
  logic wr_en;
  logic pred_x_q;
  logic pred_x_d;

  // Reset dominates training so a reset cycle never allocates
  assign wr_en = check_is_br && !stall && !rst;

  bp_table #(
    .PC_WIDTH (PC_WIDTH),
    .LINES    (LINES)
  ) u_table (
    .clk_i      (clk),
    .rst_i      (rst),
    .rd_pc_i    (guess_pc),
    .rd_hit_o   (rd_hit),
    .rd_ctr_o   (rd_ctr),
    .wr_en_i    (wr_en),
    .wr_pc_i    (check_pc),
    .wr_taken_i (check_taken)
  );

  assign br_pred_taken = guess_is_br && rd_hit && rd_ctr[1];

  always_comb begin
    pred_x_d = pred_x_q;
    if (!stall) begin
      pred_x_d = br_pred_taken;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pred_x_q <= 1'b0;
    end else begin
      pred_x_q <= pred_x_d;
    end
  end

  assign br_pred_correct = !check_is_br || (pred_x_q == check_taken);

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: randomized and directed stimulus
// against an array-based reference model of the predictor table.
module tb_branch_predictor;

  localparam int PC_WIDTH = 32;
  localparam int LINES    = 8;
  localparam int IB       = 3;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                stall = 1'b0;
  logic [PC_WIDTH-1:0] guess_pc = '0;
  logic                guess_is_br = 1'b0;
  logic                br_pred_taken;
  logic [PC_WIDTH-1:0] check_pc = '0;
  logic                check_is_br = 1'b0;
  logic                check_taken = 1'b0;
  logic                br_pred_correct;

  branch_predictor #(.PC_WIDTH(PC_WIDTH), .LINES(LINES)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .guess_pc        (guess_pc),
    .guess_is_br     (guess_is_br),
    .br_pred_taken   (br_pred_taken),
    .check_pc        (check_pc),
    .check_is_br     (check_is_br),
    .check_taken     (check_taken),
    .br_pred_correct (br_pred_correct)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic taken;
    logic correct;
    int   step;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;
  int   step   = 0;
  bit   done   = 0;

  // Reference model state
  bit          m_valid [LINES];
  int unsigned m_tag   [LINES];
  int          m_ctr   [LINES];
  bit          m_pred_x;

  // Inputs that will be sampled at the next edge, plus the prediction expected for them
  bit          c_rst = 1, c_stall = 0, c_cbr = 0, c_ctaken = 0, c_exp_taken = 0;
  int unsigned c_cpc = 0;

  function automatic int idx_of(input int unsigned pc);
    return (pc >> 2) % LINES;
  endfunction

  function automatic int unsigned tag_of(input int unsigned pc);
    return pc >> (IB + 2);
  endfunction

  function automatic int trained(input bit hit, input int ctr, input bit taken);
    if (!hit) return taken ? 2 : 1;
    if (taken) return (ctr + 1 > 3) ? 3 : ctr + 1;
    return (ctr - 1 < 0) ? 0 : ctr - 1;
  endfunction

  task automatic model_edge();
    if (c_rst) begin
      for (int i = 0; i < LINES; i++) begin
        m_valid[i] = 0;
        m_tag[i]   = 0;
        m_ctr[i]   = 1;
      end
      m_pred_x = 0;
    end else if (!c_stall) begin
      m_pred_x = c_exp_taken;
      if (c_cbr) begin
        int  i;
        bit  hit;
        i   = idx_of(c_cpc);
        hit = m_valid[i] && (m_tag[i] == tag_of(c_cpc));
        m_ctr[i]   = trained(hit, m_ctr[i], c_ctaken);
        m_valid[i] = 1;
        m_tag[i]   = tag_of(c_cpc);
      end
    end
  endtask

  task automatic drive(input bit r, input bit s, input int unsigned gpc, input bit gbr,
                       input int unsigned cpc, input bit cbr, input bit ct);
    exp_t        e;
    int          gi;
    bit          v;
    int unsigned t;
    int          c;
    @(posedge clk);
    #1;
    model_edge();
    rst = r; stall = s; guess_pc = gpc; guess_is_br = gbr;
    check_pc = cpc; check_is_br = cbr; check_taken = ct;
    c_rst = r; c_stall = s; c_cbr = cbr; c_ctaken = ct; c_cpc = cpc;
    gi = idx_of(gpc);
    v = m_valid[gi]; t = m_tag[gi]; c = m_ctr[gi];
`ifdef BRANCH_PREDICTOR_BYPASS_EN
    if (!r && !s && cbr && idx_of(cpc) == gi) begin
      c = trained(m_valid[gi] && (m_tag[gi] == tag_of(cpc)), m_ctr[gi], ct);
      v = 1;
      t = tag_of(cpc);
    end
`endif
    e.taken   = gbr && v && (t == tag_of(gpc)) && (c >= 2);
    e.correct = !cbr || (m_pred_x == ct);
    e.step    = step;
    c_exp_taken = e.taken;
    exp_q.push_back(e);
    step++;
  endtask

  // Monitor: one expected response per cycle, compared away from the clock edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (br_pred_taken === e.taken) passed++;
        else $display("FAIL pred_taken step=%0d got=%b exp=%b", e.step, br_pred_taken, e.taken);
        checks++;
        if (br_pred_correct === e.correct) passed++;
        else $display("FAIL pred_correct step=%0d got=%b exp=%b", e.step, br_pred_correct, e.correct);
      end
    end
  end

  function automatic int unsigned rand_pc();
    int unsigned hi;
    hi = ($urandom_range(0, 9) == 0) ? 32'h8000_0000 : 32'h0000_0100;
    return hi + ($urandom_range(0, 3) << (IB + 2)) + ($urandom_range(0, 3) << 2)
           + $urandom_range(0, 3);
  endfunction

  initial begin
    // Reset, then lookup with no training
    drive(1, 0, 'h100, 1, 0, 0, 0);
    drive(1, 0, 'h100, 1, 0, 0, 0);
    drive(0, 0, 'h100, 1, 0, 0, 0);
    // Train taken, then predict taken
    drive(0, 0, 'h100, 1, 'h100, 1, 1);
    drive(0, 0, 'h100, 1, 'h100, 1, 1);
    drive(0, 0, 'h100, 1, 'h100, 1, 1);
    drive(0, 0, 'h100, 1, 'h100, 1, 1);
    // Hysteresis: two not-taken
    drive(0, 0, 'h100, 1, 'h100, 1, 0);
    drive(0, 0, 'h100, 1, 'h100, 1, 0);
    drive(0, 0, 'h100, 1, 0, 0, 0);
    // Aliasing at the same index with a different tag
    drive(0, 0, 'h100, 1, 'h100, 1, 1);
    drive(0, 0, 'h120, 1, 'h100, 1, 1);
    drive(0, 0, 'h120, 1, 'h120, 1, 1);
    drive(0, 0, 'h120, 1, 0, 0, 0);
    drive(0, 0, 'h100, 1, 0, 0, 0);
    // Stall holds pred_x and blocks training
    for (int i = 0; i < 3; i++) drive(0, 1, 'h120, 1, 'h10C, 1, 1);
    drive(0, 0, 'h10C, 1, 'h10C, 1, 1);
    drive(0, 0, 'h10C, 1, 'h10C, 1, 0);
    drive(0, 0, 'h10C, 1, 0, 0, 0);
    // Same-cycle update and lookup from a weak-not-taken entry
    drive(0, 0, 'h114, 0, 'h114, 1, 0);
    drive(0, 0, 'h114, 1, 'h114, 1, 1);
    drive(0, 0, 'h114, 1, 0, 0, 0);
    // Non-branch in IF never predicts taken
    drive(0, 0, 'h10C, 0, 0, 0, 0);
    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 4) == 0), rand_pc(),
            ($urandom_range(0, 3) != 0), rand_pc(), ($urandom_range(0, 2) != 0),
            $urandom_range(0, 1));
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL drain got=%0d pending exp=0", exp_q.size());
    $display("%0d/%0d checks passed", passed, checks);
    done = 1;
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Dynamic branch predictor feeding the front-end control logic of the 3-stage RISC-V core (IF, X, WB).
- Predicts the branch in IF from a tagged, direct-mapped table of 2-bit saturating counters.
- Carries each prediction to X internally and produces br_pred_correct against the resolved outcome.
- Trains the table when the branch resolves in X.

Parameters:
- PC_WIDTH, 32, instruction address width.
- LINES, 8, table entries; power of 2, minimum 2.
- INDEX_BITS, log2(LINES), derived; not overridable.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- stall  in  1  pipeline hold; IF to X advance suppressed
- guess_pc  in  PC_WIDTH  PC of the instruction in IF
- guess_is_br  in  1  IF instruction is a conditional branch
- br_pred_taken  out  1  prediction for the IF branch, combinational
- check_pc  in  PC_WIDTH  PC of the instruction in X
- check_is_br  in  1  X instruction is a conditional branch (not flushed)
- check_taken  in  1  resolved outcome from the branch comparator
- br_pred_correct  out  1  high unless the X branch was mispredicted

Behaviour:
- Interface: single clock clk; reset rst is synchronous and active-high.
- Address split:
  - index = pc[INDEX_BITS+1:2]
  - tag = pc[PC_WIDTH-1:INDEX_BITS+2]
  - pc[1:0] ignored.
- Entry fields: valid(1), tag, ctr(2). Encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Lookup (combinational, same cycle):
  - hit_g = valid[index_g] && tag match.
  - br_pred_taken = guess_is_br && hit_g && ctr[index_g][1].
- Prediction pipe:
  - Register pred_x <= br_pred_taken on each posedge where !stall.
  - Holds its value while stall is high.
- Check (combinational): br_pred_correct = !check_is_br || (pred_x == check_taken).
- Update (posedge, only when check_is_br && !stall):
  - Hit on check_pc: ctr saturating +1 if taken, -1 if not. 11 stays 11 on taken; 00 stays 00 on not-taken.
  - Miss: allocate valid=1, tag=check tag, ctr = taken ? 10 : 01. This overwrites any aliasing entry.
- No update when check_is_br is low or stall is high. A stalled X instruction is therefore trained exactly once.
- Same-index read/write in one cycle: lookup sees the pre-update value (no forwarding) unless the optional feature is compiled in.
- Reset:
  - All valid cleared; ctr = 01 in every entry; pred_x = 0.
  - After reset: br_pred_taken = 0 and br_pred_correct = 1 until trained.
- rst overrides stall and any in-flight update. Reset mid-operation discards all history.
- Latency: prediction 0 cycles; update visible to lookup 1 cycle after the training edge.

Optional Feature:
- Macro: BRANCH_PREDICTOR_BYPASS_EN.
- Defined:
  - When an update targets the same index as the current lookup in the same cycle, the lookup uses the post-update entry (valid, tag, ctr).
  - br_pred_taken then reflects the training in that cycle.
- Undefined: lookup reads the stored entry; the update takes effect next cycle.

Decomposition:
- Shared package holds:
  - 2-bit counter encoding constants: CTR_SNT=00, CTR_WNT=01, CTR_WT=10, CTR_ST=11.
  - CTR_RESET = CTR_WNT.
  - Branch opcode constant, shared with the control logic.
- Natural sub-module: bp_table, holding the valid/tag/ctr storage.
  - One combinational read port.
  - One synchronous write port with saturating-update logic.
  - Synchronous clear on rst.
  - Contains the bypass mux when the feature is enabled.
- Top level holds the pred_x register and the correctness compare.

Test Plan:
- Reset:
  - Stimulus: rst high 2 cycles, then guess_pc=0x100, guess_is_br=1.
  - Response: br_pred_taken=0. With check_is_br=0, br_pred_correct=1.
- Training to taken:
  - Stimulus: check_pc=0x100, check_taken=1 (miss allocates 10). Next cycle guess_pc=0x100.
  - Response: br_pred_taken=1. After pipe advance, check_taken=1 gives br_pred_correct=1.
- Saturation and hysteresis:
  - Stimulus: train 0x100 taken 3 times (ctr=11), then one not-taken (ctr=10).
  - Response: prediction still 1. A second not-taken (ctr=01) makes the prediction 0.
- Mispredict and aliasing:
  - Stimulus: with LINES=8, train 0x100 taken, then look up 0x120 (same index, different tag).
  - Response: br_pred_taken=0 (miss).
  - Stimulus: resolve 0x120 as taken against pred_x=0.
  - Response: br_pred_correct=0 and the entry is reallocated to 0x120 with ctr=10.
- Stall:
  - Stimulus: stall=1 for 3 cycles with check_is_br=1, check_taken=1 at a fresh PC.
  - Response: pred_x constant and exactly one allocation, so ctr=10 rather than 11 after release.
- Simultaneous update and lookup at the same index:
  - Stimulus: entry ctr=01, training taken, lookup of the same PC in the same cycle.
  - Response: br_pred_taken=0 with BRANCH_PREDICTOR_BYPASS_EN undefined; 1 with it defined.
